game_frame_scheduler: RTL and testbench

GAME_FRAME_SCHEDULER -- requirements
Module: game_frame_scheduler

---
 rtl/game_frame_scheduler_pkg.sv | 24 ++
 rtl/sched_watchdog.sv | 44 ++++
 rtl/game_frame_scheduler.sv | 176 +++++++++++++++++
 tb/tb_game_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_frame_scheduler_pkg.sv
// rtl/game_frame_scheduler_pkg.sv - shared task indices, FSM encoding and helpers for the frame scheduler
// Contents: TASK_* task index constants, NUM_TASKS, sched_state_e, task_onehot().

package game_frame_scheduler_pkg;

  localparam int NUM_TASKS = 4;

  localparam logic [1:0] TASK_PLAYER    = 2'd0;
  localparam logic [1:0] TASK_BULLETS   = 2'd1;
  localparam logic [1:0] TASK_ALIENS    = 2'd2;
  localparam logic [1:0] TASK_COLLISION = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } sched_state_e;

  function automatic logic [NUM_TASKS-1:0] task_onehot(input logic [1:0] idx);
    return {{(NUM_TASKS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/sched_watchdog.sv
// rtl/sched_watchdog.sv - per-task WAIT-cycle watchdog for the frame scheduler
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-high reset
//   clear    in   zero the counter (held while the scheduler is outside WAIT)
//   enable   in   count one WAIT cycle
//   expired  out  high in the LIMIT-th consecutive enabled cycle

module sched_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle that would make the count reach LIMIT is the one that trips,
  // so WAIT lasts exactly LIMIT cycles before the scheduler moves on.
  assign expired = enable && !clear && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/game_frame_scheduler.sv
// rtl/game_frame_scheduler.sv - sequences the per-frame game tasks during vertical blanking
// Optional build macro: SCHED_WATCHDOG_EN (adds the per-task watchdog and timeout flag).
// Ports:
//   clk          in   pixel clock
//   reset        in   asynchronous active-high reset
//   hpos, vpos   in   [9:0] beam position from the sync generator
//   pause        in   blocks new sequences at the trigger
//   task_done    in   [3:0] per-task completion (0 player, 1 bullets, 2 aliens, 3 collision)
//   task_start   out  [3:0] one-cycle start pulse per task
//   busy         out  sequence in progress
//   frame_done   out  one-cycle pulse at sequence end
//   frame_count  out  [7:0] started sequences, wrapping
//   overrun      out  sticky: frame boundary reached while busy
//   timeout      out  sticky: a task was abandoned by the watchdog

module game_frame_scheduler
  import game_frame_scheduler_pkg::*;
#(
  parameter int V_DISPLAY = 480,
  parameter int ALIEN_DIV = 8,
  parameter int WD_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [9:0]     hpos,
  input  logic [9:0]     vpos,
  input  logic           pause,
  input  logic [3:0]     task_done,
  output logic [3:0]     task_start,
  output logic           busy,
  output logic           frame_done,
  output logic [7:0]     frame_count,
  output logic           overrun,
  output logic           timeout
);

  sched_state_e   state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     div_q, div_d;
  logic           aliens_en_q, aliens_en_d;
  logic [7:0]     count_q, count_d;
  logic [3:0]     start_q, start_d;
  logic           busy_q, frame_done_q;
  logic           overrun_q, overrun_d;

  logic trigger, frame_wrap, done_seen, advance;

  assign trigger    = (hpos == 10'd0) && (vpos == 10'(V_DISPLAY));
  assign frame_wrap = (hpos == 10'd0) && (vpos == 10'd0);

  // A task cannot complete in the same cycle its start pulse is on the wire.
  assign done_seen  = task_done[idx_q] && (start_q == 4'd0);

`ifdef SCHED_WATCHDOG_EN
  logic wd_expired;
  logic timeout_q, timeout_d;

  sched_watchdog #(
    .LIMIT (WD_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != WAIT),
    .enable  (state_q == WAIT),
    .expired (wd_expired)
  );

  assign advance = done_seen || wd_expired;
`else
  assign advance = done_seen;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    div_d       = div_q;
    aliens_en_d = aliens_en_q;
    count_d     = count_q;
    start_d     = 4'd0;
    overrun_d   = overrun_q;
`ifdef SCHED_WATCHDOG_EN
    timeout_d   = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (trigger && !pause) begin
          state_d     = ISSUE;
          idx_d       = TASK_PLAYER;
          count_d     = count_q + 8'd1;
          // Latch this frame's alien decision before the divider moves on.
          aliens_en_d = (div_q == 8'd0);
          div_d       = (div_q == 8'(ALIEN_DIV - 1)) ? 8'd0 : div_q + 8'd1;
        end
      end
      ISSUE: begin
        if ((idx_q == TASK_ALIENS) && !aliens_en_q) begin
          idx_d = idx_q + 2'd1;
        end else begin
          start_d = task_onehot(idx_q);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (advance) begin
`ifdef SCHED_WATCHDOG_EN
          if (!done_seen) begin
            timeout_d = 1'b1;
          end
`endif
          if (idx_q == TASK_COLLISION) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ISSUE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != IDLE) && (trigger || frame_wrap)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= TASK_PLAYER;
      div_q        <= 8'd0;
      aliens_en_q  <= 1'b0;
      count_q      <= 8'd0;
      start_q      <= 4'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      div_q        <= div_d;
      aliens_en_q  <= aliens_en_d;
      count_q      <= count_d;
      start_q      <= start_d;
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == FINISH);
      overrun_q    <= overrun_d;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign task_start  = start_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_game_frame_scheduler.sv
// tb/tb_game_frame_scheduler.sv - randomized self-checking bench for game_frame_scheduler

module tb_game_frame_scheduler;

  localparam int VD = 480;
  localparam int AD = 8;
  localparam int WD = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hpos = 10'd7;
  logic [9:0] vpos = 10'd100;
  logic       pause = 1'b0;
  logic [3:0] task_done = 4'd0;
  logic [3:0] task_start;
  logic       busy, frame_done, overrun, timeout;
  logic [7:0] frame_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state: started sequences since reset, sticky flags.
  int m_count = 0;
  int m_frames = 0;
  int m_overrun = 0;
  int m_timeout = 0;

  always #5 clk = ~clk;

  game_frame_scheduler #(
    .V_DISPLAY (VD),
    .ALIEN_DIV (AD),
    .WD_CYCLES (WD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .pause       (pause),
    .task_done   (task_done),
    .task_start  (task_start),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_pos();
    hpos = 10'($urandom_range(1, 799));
    vpos = 10'd100;
  endtask

  task automatic wait_start(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (task_start != 4'd0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // mode: 0 normal, 1 hold task 1 across frame wrap and a second trigger,
  //       2 task 3 never completes on its own, 3 reset while waiting on task 1
  task automatic run_frame(input int mode, input bit pz, input int fixed_lat);
    int         order[$];
    int         exp_cyc, n_done, lat, nf;
    bit         got;
    logic [3:0] bm;

    pause     = pz;
    task_done = 4'd0;
    hpos      = 10'd0;
    vpos      = 10'(VD);
    exp_cyc   = cyc + 2;
    n_done    = 0;
    step();
    idle_pos();

    if (pz) begin
      for (int i = 0; i < 4; i++) begin
        chk("paused_start", task_start, 0);
        chk("paused_busy", busy, 0);
        step();
      end
      chk("paused_count", frame_count, m_count);
      pause = 1'b0;
      return;
    end

    m_count = (m_count + 1) % 256;
    nf = m_frames;
    m_frames++;
    order.push_back(0);
    order.push_back(1);
    if (nf % AD == 0) order.push_back(2);
    order.push_back(3);

    chk("busy_after_trigger", busy, 1);

    for (int k = 0; k < order.size(); k++) begin
      wait_start(20, got);
      if (!got) begin
        chk("start_seen", 0, 1);
        return;
      end
      chk("start_cycle", cyc, exp_cyc);
      chk("start_onehot", task_start, 32'(4'b1 << order[k]));
      chk("count_in_seq", frame_count, m_count);
      bm = 4'b1 << order[k];
      if (k > 0) pause = 1'($urandom_range(0, 1));
      // Any value here, including the active bit, must be ignored.
      task_done = 4'($urandom);

      if (mode == 3 && order[k] == 1) begin
        step();
        task_done = 4'd0;
        reset = 1'b1;
        step();
        chk("rst_start", task_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b0;
        m_count = 0;
        m_frames = 0;
        m_overrun = 0;
        m_timeout = 0;
        return;
      end

      if (mode == 1 && order[k] == 1) begin
        step();
        task_done = 4'($urandom) & ~bm;
        hpos = 10'd0;
        vpos = 10'd0;
        step();
        idle_pos();
        chk("overrun_wrap", overrun, 1);
        m_overrun = 1;
        hpos = 10'd0;
        vpos = 10'(VD);
        step();
        idle_pos();
        for (int i = 0; i < 5; i++) begin
          chk("no_restart_start", task_start, 0);
          chk("no_restart_busy", busy, 1);
          step();
        end
        chk("no_restart_count", frame_count, m_count);
      end

      if (mode == 2 && order[k] == 3) begin
`ifdef SCHED_WATCHDOG_EN
        for (int i = 1; i <= WD; i++) begin
          step();
          task_done = 4'($urandom) & ~bm;
          if (i == WD - 1) chk("timeout_early", timeout, 0);
        end
        chk("timeout_set", timeout, 1);
        chk("wd_frame_done", frame_done, 1);
        m_timeout = 1;
        step();
        task_done = 4'd0;
        chk("wd_frame_done_once", frame_done, 0);
        chk("wd_idle", busy, 0);
        return;
`else
        for (int i = 1; i <= 3 * WD; i++) begin
          step();
          task_done = 4'($urandom) & ~bm;
        end
        chk("hang_busy", busy, 1);
        chk("hang_timeout", timeout, 0);
`endif
      end

      lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 5);
      for (int c = 1; c <= lat; c++) begin
        step();
        chk("single_pulse", task_start, 0);
        task_done = (c == lat) ? (4'($urandom) | bm) : (4'($urandom) & ~bm);
      end
      n_done = cyc;
      exp_cyc = n_done + 2;
      if (k + 1 < order.size() && order[k] == 1 && order[k+1] == 3) exp_cyc++;
    end

    step();
    task_done = 4'd0;
    chk("frame_done", frame_done, 1);
    step();
    chk("frame_done_once", frame_done, 0);
    chk("idle_busy", busy, 0);
    chk("frame_count", frame_count, m_count);
    chk("overrun_flag", overrun, m_overrun);
    chk("timeout_flag", timeout, m_timeout);
  endtask

  initial begin
    repeat (3) step();
    chk("reset_start", task_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_count", frame_count, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_timeout", timeout, 0);
    reset = 1'b0;
    repeat (2) step();

    run_frame(0, 1'b0, 3);
    chk("first_frame_count", frame_count, 1);

    for (int f = 0; f < 17; f++) begin
      repeat ($urandom_range(1, 6)) begin
        idle_pos();
        step();
      end
      run_frame(0, (f == 5), 0);
    end

    run_frame(1, 1'b0, 0);
    repeat (3) step();
    run_frame(2, 1'b0, 0);
    repeat (3) step();
    run_frame(3, 1'b0, 0);
    repeat (3) step();
    run_frame(0, 1'b0, 0);
    chk("post_reset_count", frame_count, 1);

    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(1, 6)) begin
        idle_pos();
        step();
      end
      run_frame(0, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
